// File: rtl/byte_striping_tx.sv
// Transmit-side byte striper: distributes a serial byte stream round-robin into four lanes
// and presents each completed group on a registered valid/ready output stage.
module byte_striping_tx #(
    parameter logic [7:0]  PAD_BYTE = 8'h00,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    input  logic [7:0]       data_in,
    output logic             ready_in,
    input  logic             sof,
    input  logic             flush,
    output logic [7:0]       data_out0,
    output logic [7:0]       data_out1,
    output logic [7:0]       data_out2,
    output logic [7:0]       data_out3,
    output logic             valid_out,
    input  logic             out_ready,
    output logic [3:0]       lane_fill,
    output logic             err_sof,
    output logic [CNT_W-1:0] group_count
);

    typedef enum logic [0:0] {StFill, StFull} state_e;

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    state_e     state_q;
    logic [1:0] ptr_q;
    logic [7:0] lane_q [4];

    logic       full;
    logic       accept;
    logic       drain;
    logic       out_free;
    logic       discard;
    logic       flush_pad;
    logic       group_done;
    logic [7:0] nxt_lane [4];
    logic [3:0] nxt_fill;
    logic [1:0] nxt_ptr;

    // Back-pressure comes only from the full flag, so ready_in never depends on out_ready.
    assign full     = (state_q == StFull);
    assign ready_in = !full;

    always_comb begin
        accept   = valid_in && ready_in;
        drain    = valid_out && out_ready;
        out_free = !valid_out || out_ready;
        for (int i = 0; i < 4; i++) begin
            nxt_lane[i] = lane_q[i];
        end
        nxt_fill = lane_fill;
        nxt_ptr  = ptr_q;
        discard  = 1'b0;

        if (accept) begin
            if (sof) begin
                discard     = (ptr_q != 2'd0);
                nxt_lane[0] = data_in;
                nxt_fill    = 4'b0001;
                nxt_ptr     = 2'd1;
            end else begin
                nxt_lane[ptr_q] = data_in;
                nxt_fill[ptr_q] = 1'b1;
                nxt_ptr         = ptr_q + 2'd1;
            end
        end

        // Flush acts on the state after this cycle's byte; an empty group needs no padding.
        flush_pad = flush && (state_q == StFill) && (nxt_ptr != 2'd0);
        if (flush_pad) begin
            for (int i = 0; i < 4; i++) begin
                if (!nxt_fill[i]) begin
                    nxt_lane[i] = PAD_BYTE;
                end
            end
        end

        group_done = (accept && !sof && (ptr_q == 2'd3)) || flush_pad;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StFill;
            ptr_q       <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                lane_q[i] <= 8'h00;
            end
            lane_fill   <= 4'b0000;
            data_out0   <= 8'h00;
            data_out1   <= 8'h00;
            data_out2   <= 8'h00;
            data_out3   <= 8'h00;
            valid_out   <= 1'b0;
            err_sof     <= 1'b0;
            group_count <= '0;
        end else begin
            err_sof <= discard;
            if (drain) begin
                valid_out   <= 1'b0;
                group_count <= group_count + CntOne;
            end

            case (state_q)
                StFill: begin
                    if (group_done) begin
                        ptr_q <= 2'd0;
                        if (out_free) begin
                            data_out0 <= nxt_lane[0];
                            data_out1 <= nxt_lane[1];
                            data_out2 <= nxt_lane[2];
                            data_out3 <= nxt_lane[3];
                            valid_out <= 1'b1;
                            lane_fill <= 4'b0000;
                        end else begin
                            for (int i = 0; i < 4; i++) begin
                                lane_q[i] <= nxt_lane[i];
                            end
                            lane_fill <= 4'b1111;
                            state_q   <= StFull;
                        end
                    end else begin
                        for (int i = 0; i < 4; i++) begin
                            lane_q[i] <= nxt_lane[i];
                        end
                        lane_fill <= nxt_fill;
                        ptr_q     <= nxt_ptr;
                    end
                end
                StFull: begin
                    // valid_out is always set while a group is held here.
                    if (out_ready) begin
                        data_out0 <= lane_q[0];
                        data_out1 <= lane_q[1];
                        data_out2 <= lane_q[2];
                        data_out3 <= lane_q[3];
                        valid_out <= 1'b1;
                        lane_fill <= 4'b0000;
                        state_q   <= StFill;
                    end
                end
                default: state_q <= StFill;
            endcase
        end
    end

endmodule

// File: tb/tb_byte_striping_tx.sv
// Scoreboard bench for byte_striping_tx: stimulus queues expected groups, a monitor
// compares each delivered group and the running group count.
module tb_byte_striping_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic       valid_in;
    logic [7:0] data_in;
    logic       sof;
    logic       flush;
    logic       out_ready;

    logic       ready_in, valid_out, err_sof;
    logic [7:0] data_out0, data_out1, data_out2, data_out3;
    logic [3:0] lane_fill;
    logic [7:0] group_count;

    logic       ready_in_b, valid_out_b, err_sof_b;
    logic [7:0] data_out0_b, data_out1_b, data_out2_b, data_out3_b;
    logic [3:0] lane_fill_b;
    logic [1:0] group_count_b;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    int          hs_model = 0;
    bit          cnt_pending = 1'b0;

    byte_striping_tx #(.PAD_BYTE(8'h00), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in),
        .ready_in(ready_in), .sof(sof), .flush(flush),
        .data_out0(data_out0), .data_out1(data_out1), .data_out2(data_out2),
        .data_out3(data_out3), .valid_out(valid_out), .out_ready(out_ready),
        .lane_fill(lane_fill), .err_sof(err_sof), .group_count(group_count)
    );

    byte_striping_tx #(.PAD_BYTE(8'h00), .CNT_W(2)) dut_w2 (
        .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in),
        .ready_in(ready_in_b), .sof(sof), .flush(flush),
        .data_out0(data_out0_b), .data_out1(data_out1_b), .data_out2(data_out2_b),
        .data_out3(data_out3_b), .valid_out(valid_out_b), .out_ready(out_ready),
        .lane_fill(lane_fill_b), .err_sof(err_sof_b), .group_count(group_count_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a handshake is visible at the negedge before the edge that completes it.
    initial begin
        forever begin
            @(negedge clk);
            if (cnt_pending) begin
                check("group_count", {24'b0, group_count}, 32'(hs_model & 255));
                check("group_count_w2", {30'b0, group_count_b}, 32'(hs_model & 3));
                cnt_pending = 1'b0;
            end
            if (reset && valid_out && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_group: got %h expected none",
                             {data_out0, data_out1, data_out2, data_out3});
                end else begin
                    check("group_data", {data_out0, data_out1, data_out2, data_out3},
                          exp_q.pop_front());
                end
                hs_model++;
                cnt_pending = 1'b1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b, input logic s = 1'b0, input logic f = 1'b0);
        bit acc;
        int n;
        n = 0;
        valid_in = 1'b1;
        data_in  = b;
        sof      = s;
        flush    = f;
        do begin
            @(negedge clk);
            acc = ready_in;
            tick();
            n++;
        end while (!acc && n < 50);
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: got ready_in=0 expected 1 for byte %h", b);
        end
        valid_in = 1'b0;
        sof      = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        exp_q.delete();
        hs_model    = 0;
        cnt_pending = 1'b0;
        tick();
        check("rst_data", {data_out0, data_out1, data_out2, data_out3}, 32'h0);
        check("rst_valid", {31'b0, valid_out}, 32'd0);
        check("rst_fill", {28'b0, lane_fill}, 32'd0);
        check("rst_err", {31'b0, err_sof}, 32'd0);
        check("rst_count", {24'b0, group_count}, 32'd0);
        check("rst_ready", {31'b0, ready_in}, 32'd1);
        reset = 1'b1;
        tick();
    endtask

    initial begin
        reset     = 1'b0;
        valid_in  = 1'b0;
        data_in   = 8'h00;
        sof       = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        tick();
        do_reset();

        // Basic group with no back-pressure
        exp_q.push_back(32'h11223344);
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        check("latency_valid", {31'b0, valid_out}, 32'd1);
        tick();
        check("valid_one_cycle", {31'b0, valid_out}, 32'd0);
        tick();

        // Back-pressure: second group parks in the collect stage
        do_reset();
        out_ready = 1'b0;
        exp_q.push_back(32'h01020304);
        exp_q.push_back(32'h05060708);
        for (int i = 1; i <= 8; i++) push(8'(i));
        check("bp_ready_low", {31'b0, ready_in}, 32'd0);
        check("bp_data_hold", {data_out0, data_out1, data_out2, data_out3}, 32'h01020304);
        tick(); tick();
        check("bp_ready_still_low", {31'b0, ready_in}, 32'd0);
        check("bp_data_stable", {data_out0, data_out1, data_out2, data_out3}, 32'h01020304);
        check("bp_valid_held", {31'b0, valid_out}, 32'd1);
        out_ready = 1'b1;
        tick();
        check("bp_ready_back", {31'b0, ready_in}, 32'd1);
        check("bp_second_group", {data_out0, data_out1, data_out2, data_out3}, 32'h05060708);
        tick();
        check("bp_drained", {31'b0, valid_out}, 32'd0);
        check("bp_data_retained", {data_out0, data_out1, data_out2, data_out3}, 32'h05060708);
        tick();

        // Flush with padding, then flush on an empty group
        do_reset();
        exp_q.push_back(32'hAABB0000);
        push(8'hAA); push(8'hBB);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_valid", {31'b0, valid_out}, 32'd1);
        tick(); tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_empty_noop", {31'b0, valid_out}, 32'd0);
        tick();
        check("flush_empty_noop2", {31'b0, valid_out}, 32'd0);
        exp_q.push_back(32'hC5000000);
        push(8'hC5, 1'b1, 1'b1);
        check("sof_flush_no_err", {31'b0, err_sof}, 32'd0);
        check("sof_flush_valid", {31'b0, valid_out}, 32'd1);
        tick(); tick();

        // sof realigns a partial group
        do_reset();
        exp_q.push_back(32'h30405060);
        push(8'h10); push(8'h20);
        push(8'h30, 1'b1);
        check("sof_err_pulse", {31'b0, err_sof}, 32'd1);
        check("sof_fill", {28'b0, lane_fill}, 32'h1);
        push(8'h40);
        check("sof_err_clear", {31'b0, err_sof}, 32'd0);
        check("sof_fill2", {28'b0, lane_fill}, 32'h3);
        push(8'h50); push(8'h60);
        tick(); tick(); tick();

        // Reset in the middle of a group loses the partial bytes
        do_reset();
        push(8'h77); push(8'h88);
        do_reset();
        exp_q.push_back(32'h01020304);
        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        tick(); tick(); tick();

        // Five groups: the narrow counter wraps 1,2,3,0,1
        do_reset();
        for (int g = 0; g < 5; g++) begin
            logic [7:0] b0, b1, b2, b3;
            b0 = 8'(g * 16 + 1);
            b1 = 8'(g * 16 + 2);
            b2 = 8'(g * 16 + 3);
            b3 = 8'(g * 16 + 4);
            exp_q.push_back({b0, b1, b2, b3});
            push(b0); push(b1); push(b2); push(b3);
        end
        tick(); tick(); tick();
        check("final_count", {24'b0, group_count}, 32'd5);
        check("final_count_w2", {30'b0, group_count_b}, 32'd1);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
